combo_seq_detector: RTL and testbench

- Parametrised successor to the fixed left-down-right-attack combo checker.
- Watches the player's button vector for rising-edge presses. Detects a runtime-programmable ordered sequence of SEQ_LEN presses, with a per-step timeout window.
- Issues a held success flag plus a one-cycle fire pulse.
- Sits between the input-sync stage and the fighter move/attack FSM; one instance per combo per player.

---
 rtl/combo_seq_detector_pkg.sv | 37 +++
 rtl/combo_seq_detector_btn_edge_detect.sv | 22 ++
 rtl/combo_seq_detector.sv | 189 ++++++++++++++++++
 tb/tb_combo_seq_detector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combo_seq_detector_pkg.sv
// Shared button indices, FSM state type and a helper that packs a step list into combo_seq.
package combo_pkg;

    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_ATTACK = 4;
    localparam int unsigned BTN_BLOCK  = 5;

    localparam int unsigned DEFAULT_IDX_W = 3;
    localparam int unsigned MAX_SEQ_LEN   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } combo_state_t;

    typedef int unsigned combo_list_t [MAX_SEQ_LEN];

    // Step 0 lands in the LSBs; entries at or beyond len are left zero.
    function automatic logic [MAX_SEQ_LEN*DEFAULT_IDX_W-1:0] pack_combo(
        input combo_list_t steps,
        input int unsigned len
    );
        logic [MAX_SEQ_LEN*DEFAULT_IDX_W-1:0] seq_bits;
        seq_bits = '0;
        for (int unsigned i = 0; i < MAX_SEQ_LEN; i++) begin
            if (i < len) begin
                seq_bits[i*DEFAULT_IDX_W +: DEFAULT_IDX_W] = steps[i][DEFAULT_IDX_W-1:0];
            end
        end
        return seq_bits;
    endfunction

endpackage

// File: rtl/combo_seq_detector_btn_edge_detect.sv
// Rising-edge detector for the button vector, flagging cycles with more than one new press.
module btn_edge_detect #(
    parameter int unsigned NUM_BTNS = 6
) (
    input  logic                clk,
    input  logic [NUM_BTNS-1:0] i_btn,
    output logic [NUM_BTNS-1:0] o_rise,
    output logic                o_multi
);

    logic [NUM_BTNS-1:0] r_btn_prev;

    // Loading the live levels every cycle, reset included, keeps held buttons from looking new.
    always_ff @(posedge clk) begin
        r_btn_prev <= i_btn;
    end

    assign o_rise  = i_btn & ~r_btn_prev;
    // Clearing the lowest set bit leaves something only when two or more edges are present.
    assign o_multi = |(o_rise & (o_rise - 1'b1));

endmodule

// File: rtl/combo_seq_detector.sv
// Programmable ordered button-combo detector with per-step timeout, held success and fire pulse.
// Optional macro COMBO_LENIENT_EN: stray single presses are ignored while tracking.
module combo_seq_detector
    import combo_pkg::*;
#(
    parameter int unsigned NUM_BTNS      = 6,
    parameter int unsigned SEQ_LEN       = 4,
    parameter int unsigned IDX_W         = DEFAULT_IDX_W,
    parameter int unsigned WINDOW_CYCLES = 25_000_000,
    parameter int unsigned HOLD_CYCLES   = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_BTNS-1:0]      btn,
    input  logic [SEQ_LEN*IDX_W-1:0] combo_seq,
    input  logic                     bypass,
    output logic                     success,
    output logic                     fire,
    output logic [IDX_W:0]           progress
);

    localparam int unsigned WIN_W  = (WINDOW_CYCLES > 0) ? $clog2(WINDOW_CYCLES + 1) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned PROG_W = IDX_W + 1;

    localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WINDOW_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [PROG_W-1:0] PROG_FULL = PROG_W'(SEQ_LEN);
    localparam logic [PROG_W-1:0] PROG_LAST = PROG_W'(SEQ_LEN - 1);

    combo_state_t             r_state;
    logic [SEQ_LEN*IDX_W-1:0] r_shadow;
    logic [PROG_W-1:0]        r_progress;
    logic [WIN_W-1:0]         r_timer;
    logic [HOLD_W-1:0]        r_hold;
    logic                     r_success;
    logic                     r_fire;

    logic [NUM_BTNS-1:0]      w_rise;
    logic                     w_multi;
    logic                     w_single;
    logic                     w_start_hit;
    logic                     w_step_hit;
    logic                     w_break;
    logic                     w_timer_expired;
    logic                     w_hold_expired;
    logic [IDX_W-1:0]         w_step_idx;

    btn_edge_detect #(
        .NUM_BTNS (NUM_BTNS)
    ) u_edge (
        .clk     (clk),
        .i_btn   (btn),
        .o_rise  (w_rise),
        .o_multi (w_multi)
    );

    // Index values beyond the button count simply never match.
    function automatic logic rise_at(
        input logic [NUM_BTNS-1:0] rise,
        input logic [IDX_W-1:0]    idx
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            if (idx == IDX_W'(i)) begin
                hit = rise[i];
            end
        end
        return hit;
    endfunction

    always_comb begin
        w_step_idx = '0;
        for (int unsigned i = 0; i < SEQ_LEN; i++) begin
            if (r_progress == PROG_W'(i)) begin
                w_step_idx = r_shadow[i*IDX_W +: IDX_W];
            end
        end
    end

    assign w_single        = (|w_rise) & ~w_multi;
    assign w_start_hit     = w_single & rise_at(w_rise, combo_seq[IDX_W-1:0]);
    assign w_step_hit      = w_single & rise_at(w_rise, w_step_idx);
    assign w_timer_expired = (r_timer <= WIN_W'(1));
    assign w_hold_expired  = (r_hold <= HOLD_W'(1));

`ifdef COMBO_LENIENT_EN
    assign w_break = w_multi;
`else
    assign w_break = |w_rise;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shadow   <= '0;
            r_progress <= '0;
            r_timer    <= '0;
            r_hold     <= '0;
            r_success  <= 1'b0;
            r_fire     <= 1'b0;
        end else begin
            r_fire <= 1'b0;
            if (bypass) begin
                // Only the transition into DONE pulses fire; a held bypass just keeps reloading.
                r_state    <= DONE;
                r_fire     <= (r_state != DONE);
                r_success  <= 1'b1;
                r_hold     <= HOLD_LOAD;
                r_progress <= PROG_FULL;
                r_timer    <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start_hit) begin
                            r_shadow <= combo_seq;
                            if (SEQ_LEN == 1) begin
                                r_state    <= DONE;
                                r_fire     <= 1'b1;
                                r_success  <= 1'b1;
                                r_hold     <= HOLD_LOAD;
                                r_progress <= PROG_FULL;
                            end else begin
                                r_state    <= TRACK;
                                r_progress <= PROG_W'(1);
                                r_timer    <= WIN_LOAD;
                            end
                        end
                    end
                    TRACK: begin
                        if (w_step_hit) begin
                            if (r_progress == PROG_LAST) begin
                                r_state    <= DONE;
                                r_fire     <= 1'b1;
                                r_success  <= 1'b1;
                                r_hold     <= HOLD_LOAD;
                                r_progress <= PROG_FULL;
                                r_timer    <= '0;
                            end else begin
                                r_progress <= r_progress + 1'b1;
                                r_timer    <= WIN_LOAD;
                            end
                        end else if (w_break) begin
                            // A breaking press that is itself step 0 restarts from the live combo_seq.
                            if (w_start_hit) begin
                                r_shadow   <= combo_seq;
                                r_progress <= PROG_W'(1);
                                r_timer    <= WIN_LOAD;
                            end else begin
                                r_state    <= IDLE;
                                r_progress <= '0;
                                r_timer    <= '0;
                            end
                        end else if (w_timer_expired) begin
                            r_state    <= IDLE;
                            r_progress <= '0;
                            r_timer    <= '0;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    DONE: begin
                        if (w_hold_expired) begin
                            r_state    <= IDLE;
                            r_success  <= 1'b0;
                            r_progress <= '0;
                            r_hold     <= '0;
                        end else begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_progress <= '0;
                        r_timer    <= '0;
                        r_hold     <= '0;
                        r_success  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign success  = r_success;
    assign fire     = r_fire;
    assign progress = r_progress;

endmodule

// File: tb/tb_combo_seq_detector.sv
// Directed bench for combo_seq_detector with an edge-stamp reference model checked every cycle.
module tb_combo_seq_detector;
    import combo_pkg::*;

    localparam int unsigned NB = 6;
    localparam int unsigned SL = 4;
    localparam int unsigned IW = 3;
    localparam int          W  = 20;
    localparam int          H  = 8;
`ifdef COMBO_LENIENT_EN
    localparam bit LENIENT = 1'b1;
`else
    localparam bit LENIENT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     btn;
    logic [SL*IW-1:0]  combo_seq;
    logic              bypass;
    logic              success;
    logic              fire;
    logic [IW:0]       progress;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    combo_seq_detector #(
        .NUM_BTNS      (NB),
        .SEQ_LEN       (SL),
        .IDX_W         (IW),
        .WINDOW_CYCLES (W),
        .HOLD_CYCLES   (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .combo_seq (combo_seq),
        .bypass    (bypass),
        .success   (success),
        .fire      (fire),
        .progress  (progress)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: progress count, edge number of the last accepted press,
    // and the edge number at which the success hold ends.
    int            e = 0;
    bit            m_valid = 1'b0;
    int            m_prog = 0;
    bit            m_done = 1'b0;
    int            m_done_end = 0;
    int            m_last = 0;
    bit            m_fire = 1'b0;
    int            m_seq [SL];
    logic [NB-1:0] m_prev = '0;

    function automatic bit pressed_only(input logic [NB-1:0] r, input int idx);
        logic [NB-1:0] one;
        if (idx >= int'(NB)) return 1'b0;
        one = NB'(1) << idx;
        return r == one;
    endfunction

    task automatic m_begin();
        for (int i = 0; i < int'(SL); i++) m_seq[i] = int'(combo_seq[i*IW +: IW]);
        m_prog = 1;
        m_last = e;
        if (SL == 1) begin
            m_done = 1'b1; m_fire = 1'b1; m_done_end = e + H; m_prog = SL;
        end
    endtask

    always @(posedge clk) begin : model
        logic [NB-1:0] rise;
        int presses;
        int step0;
        e++;
        rise    = btn & ~m_prev;
        m_prev  = btn;
        presses = $countones(rise);
        step0   = int'(combo_seq[IW-1:0]);
        m_fire  = 1'b0;
        if (rst) begin
            m_valid = 1'b1; m_prog = 0; m_done = 1'b0;
        end else if (bypass) begin
            m_fire = !m_done; m_done = 1'b1; m_done_end = e + H; m_prog = SL;
        end else if (m_done) begin
            if (e >= m_done_end) begin m_done = 1'b0; m_prog = 0; end
        end else if (m_prog == 0) begin
            if (pressed_only(rise, step0)) m_begin();
        end else if (pressed_only(rise, m_seq[m_prog])) begin
            m_prog++;
            m_last = e;
            if (m_prog == int'(SL)) begin
                m_done = 1'b1; m_fire = 1'b1; m_done_end = e + H;
            end
        end else if (presses > 1 || (presses == 1 && !LENIENT)) begin
            m_prog = 0;
            if (pressed_only(rise, step0)) m_begin();
        end else if (e - m_last >= W) begin
            m_prog = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("success_vs_model", int'(success), int'(m_done));
            check("fire_vs_model", int'(fire), int'(m_fire));
            check("progress_vs_model", int'(progress), m_prog);
        end
    end

    // Called at a negedge: press idx for one cycle, check progress, then idle until gap edges have passed.
    task automatic press(input int idx, input int gap, input int exp_prog);
        btn[idx] = 1'b1;
        @(negedge clk);
        btn[idx] = 1'b0;
        if (exp_prog >= 0) check("progress_after_press", int'(progress), exp_prog);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((success || progress != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("return_to_idle", (success || progress != 0) ? 0 : 1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        combo_list_t lst;
        logic [MAX_SEQ_LEN*DEFAULT_IDX_W-1:0] packed_seq;
        int cnt, fires, highs;

        rst = 1'b1; btn = '0; bypass = 1'b0;
        lst = '{BTN_LEFT, BTN_DOWN, BTN_RIGHT, BTN_ATTACK, 0, 0, 0, 0};
        packed_seq = pack_combo(lst, SL);
        combo_seq = packed_seq[SL*IW-1:0];
        check("pack_combo", int'(combo_seq), 'h8CA);
        repeat (3) @(negedge clk);
        check("reset_progress", int'(progress), 0);
        check("reset_success", int'(success), 0);
        check("reset_fire", int'(fire), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full combo, 10 cycles apart; combo_seq scribbled mid-sequence must be ignored.
        press(BTN_LEFT, 10, 1);
        combo_seq = '0;
        press(BTN_DOWN, 10, 2);
        press(BTN_RIGHT, 10, 3);
        btn[BTN_ATTACK] = 1'b1;
        @(negedge clk);
        btn[BTN_ATTACK] = 1'b0;
        check("fire_after_attack", int'(fire), 1);
        check("success_after_attack", int'(success), 1);
        check("progress_full", int'(progress), 4);
        cnt = 0;
        for (int i = 0; i < 100 && success; i++) begin
            cnt++;
            @(negedge clk);
        end
        check("success_hold_len", cnt, H);
        check("progress_after_hold", int'(progress), 0);
        combo_seq = packed_seq[SL*IW-1:0];
        @(negedge clk);

        // Gap of W+1 before RIGHT times out; gap of exactly W is still accepted.
        press(BTN_LEFT, 10, 1);
        press(BTN_DOWN, 21, 2);
        press(BTN_RIGHT, 10, 0);
        press(BTN_ATTACK, 10, 0);
        press(BTN_LEFT, 10, 1);
        press(BTN_DOWN, 20, 2);
        press(BTN_RIGHT, 10, 3);
        press(BTN_ATTACK, 1, 4);
        wait_idle();

        // Wrong press breaks (strict); step-0 press restarts at 1.
        press(BTN_LEFT, 5, 1);
        press(BTN_DOWN, 5, 2);
        press(BTN_UP, 5, LENIENT ? 2 : 0);
        press(BTN_LEFT, 5, LENIENT ? 2 : 1);
        press(BTN_DOWN, 5, 2);
        press(BTN_LEFT, 5, LENIENT ? 2 : 1);
        repeat (30) @(negedge clk);
        check("timeout_clears", int'(progress), 0);

        // Held LEFT never advances; a double rising edge breaks.
        btn[BTN_LEFT] = 1'b1;
        @(negedge clk);
        check("held_first", int'(progress), 1);
        repeat (14) @(negedge clk);
        check("held_no_advance", int'(progress), 1);
        btn[BTN_DOWN] = 1'b1;
        btn[BTN_RIGHT] = 1'b1;
        @(negedge clk);
        check("multi_press_break", int'(progress), 0);
        repeat (85) @(negedge clk);
        check("held_after_multi", int'(progress), 0);
        btn = '0;
        repeat (2) @(negedge clk);

        // Button held through reset produces no edge afterwards.
        btn[BTN_LEFT] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("held_through_reset", int'(progress), 0);
        btn = '0;
        @(negedge clk);

        // Bypass held 5 cycles: one fire, success held through and H cycles past the last reload.
        bypass = 1'b1;
        fires = 0; highs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) check("bypass_fire_first", int'(fire), 1);
            fires += int'(fire);
            highs += int'(success);
        end
        bypass = 1'b0;
        for (int i = 0; i < 100 && success; i++) begin
            @(negedge clk);
            fires += int'(fire);
            highs += int'(success);
        end
        check("bypass_fire_count", fires, 1);
        check("bypass_success_len", highs, 4 + H);

        // Reset mid-hold and mid-sequence.
        bypass = 1'b1;
        @(negedge clk);
        bypass = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_hold_success", int'(success), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_hold_success", int'(success), 0);
        check("rst_mid_hold_fire", int'(fire), 0);
        rst = 1'b0;
        @(negedge clk);
        press(BTN_LEFT, 5, 1);
        press(BTN_DOWN, 2, 2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_seq", int'(progress), 0);
        rst = 1'b0;
        @(negedge clk);
        press(BTN_RIGHT, 5, 0);

        // Stray UP inside the combo: fires only in the lenient build.
        press(BTN_LEFT, 5, 1);
        press(BTN_UP, 5, LENIENT ? 1 : 0);
        press(BTN_DOWN, 5, LENIENT ? 2 : 0);
        press(BTN_RIGHT, 5, LENIENT ? 3 : 0);
        btn[BTN_ATTACK] = 1'b1;
        @(negedge clk);
        btn[BTN_ATTACK] = 1'b0;
        check("stray_press_fire", int'(fire), LENIENT ? 1 : 0);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
